instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the main control decoder.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Latches the returned word and presents its opcode field (op = instr[31:26]) to the decoder.
- Computes the next PC from the decoder's Branch/JMP outputs and the ALU Zero flag when the downstream datapath retires the current instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals pc
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word from memory
- instr_valid  output  1  instr/op/pc are valid and held for the decoder
- instr  output  32  latched instruction word
- op  output  6  instr[31:26], feeds decoder OP
- pc  output  32  address of the latched instruction
- pc_plus4  output  32  pc + 4 (combinational)
- retire  input  1  datapath has completed the held instruction
- branch  input  1  decoder Branch, sampled with retire
- zero  input  1  ALU zero flag, sampled with retire
- jmp  input  1  decoder JMP, sampled with retire

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=BOOT.
  - A reset in any state or mid-handshake aborts the fetch; a pending ack is discarded.
- FSM states:
  - BOOT: imem_req=0. Goes to FETCH on the next edge unconditionally, so the first request appears one cycle after reset release.
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
    - On an edge with imem_ack=1: instr<=imem_rdata, go to HOLD.
    - Otherwise stay in FETCH; req and addr stay stable.
    - Ack in the same cycle req first rises is legal (zero-wait memory).
  - HOLD: imem_req=0, instr_valid=1; instr, op and pc are held constant.
    - On an edge with retire=1: pc<=next_pc, go to FETCH.
    - Otherwise stay in HOLD.
- next_pc, evaluated in HOLD with retire=1, with priority:
  - jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - else branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32
  - else: pc_plus4
  - jmp=1 and branch=1 together: jmp wins.
- Arithmetic: all PC arithmetic is 32-bit and wraps silently (32'hFFFF_FFFC + 4 = 32'h0000_0000). Targets are always word-aligned by construction.
- Ignored inputs:
  - imem_ack outside FETCH is ignored.
  - retire outside HOLD is ignored.
  - branch, zero and jmp are sampled only on a retire edge.
- Throughput: a zero-wait memory gives one instruction per 2 cycles (FETCH, HOLD). The minimum retire-to-next-instr_valid latency is 2 edges.
- op is always instr[31:26]. After reset op=6'b000000 with instr_valid=0; the decoder output must be qualified by instr_valid.

Optional Feature:
- Macro: IFETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched (32) and perf_wait (32), both reset to 0.
  - perf_fetched increments on each FETCH→HOLD transition.
  - perf_wait increments on each cycle in FETCH with imem_ack=0.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=32'h0000_0040 and zero-wait memory returning 32'h8C01_0004 (lw):
  - imem_req rises 1 cycle after release with imem_addr=0x40.
  - instr_valid=1 next cycle with op=6'b100011 and pc=0x40.
- Wait states: hold imem_ack=0 for 3 cycles in FETCH:
  - imem_req and imem_addr are stable for 4 cycles.
  - instr_valid stays 0 until the ack edge.
  - With IFETCH_PERF_EN, perf_wait=3 and perf_fetched=1.
- Taken branch: pc=0x100, instr=32'h1022_FFFE (beq, imm=-2), retire with branch=1, zero=1 → next imem_addr=0x0FC.
- Not-taken branch: same instr with zero=0 → next imem_addr=0x104.
- Jump priority: pc=0x1000_0000, instr=32'h0810_0010, retire with jmp=1 and branch=1, zero=1 → next imem_addr=0x1040_0040.
- Async reset asserted in FETCH while imem_ack=1 in the same cycle:
  - Outputs clear immediately: instr_valid=0, imem_req=0, pc=RESET_PC.
  - The acked word is not latched.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/ack handshake, presents the latched word (and its opcode) to the main
// control decoder, and advances the PC when the datapath retires it.
// Optional build macro: IFETCH_PERF_EN adds fetch/wait performance counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory handshake
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    // towards the decoder / datapath
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        branch,
    input  logic        zero,
    input  logic        jmp
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        latch_instr;  // FETCH edge that captures imem_rdata
    logic        advance_pc;   // HOLD edge that retires the instruction
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic [31:0] jump_target;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[31:26];

    // State register; a reset anywhere abandons an in-flight fetch.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs for the BOOT -> FETCH <-> HOLD loop.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        latch_instr = 1'b0;
        advance_pc  = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    latch_instr = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (retire) begin
                    advance_pc = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Next-PC selection: jump beats branch, branch needs zero, else sequential.
    always_comb begin
        branch_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
        jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
        next_pc     = pc_plus4;
        if (jmp) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // PC and instruction registers; each only moves on its own handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= 32'd0;
        end else begin
            if (latch_instr) begin
                instr <= imem_rdata;
            end
            if (advance_pc) begin
                pc <= next_pc;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    // Performance counters: completed fetches and memory wait cycles, free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_wait    <= 32'd0;
        end else begin
            if (latch_instr) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == FETCH) && !imem_ack) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios (boot, wait states,
// taken/not-taken branch, jump priority, PC wrap, async reset mid-handshake)
// followed by randomized fetch/retire traffic checked against a PC model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        branch;
    logic        zero;
    logic        jmp;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .branch      (branch),
        .zero        (zero),
        .jmp         (jmp)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_wait   (perf_wait)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_pc;     // model: address of the instruction being fetched/held
    logic [31:0] cur_word;   // model: word the DUT should be holding
    int unsigned n_fetched;  // model: completed fetches since reset
    int unsigned n_wait;     // model: FETCH cycles without ack since reset

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, written as plain address arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (b && z) begin
            off = int'($signed(w[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    // Drive one fetch with 'waits' stall cycles; DUT must be in FETCH on entry.
    task automatic do_fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req",   {31'd0, imem_req},    32'd1);
            check("fetch_addr",  imem_addr,            exp_pc);
            check("fetch_valid", {31'd0, instr_valid}, 32'd0);
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : $urandom;
            retire     = 1'($urandom);   // must be ignored outside HOLD
            jmp        = 1'($urandom);
            branch     = 1'($urandom);
            zero       = 1'($urandom);
            tick();
            if (i < waits) n_wait++;
        end
        imem_ack = 1'b0;
        retire   = 1'b0;
        n_fetched++;
        cur_word = word;
    endtask

    // Hold for 'delay' cycles then retire with the given decoder/ALU flags.
    task automatic do_hold(input int delay, input logic j, input logic b, input logic z);
`ifdef IFETCH_PERF_EN
        check("perf_fetched", perf_fetched, n_fetched);
        check("perf_wait",    perf_wait,    n_wait);
`endif
        for (int i = 0; i <= delay; i++) begin
            check("hold_valid",  {31'd0, instr_valid}, 32'd1);
            check("hold_req",    {31'd0, imem_req},    32'd0);
            check("hold_instr",  instr,                cur_word);
            check("hold_op",     {26'd0, op},          cur_word >> 26);
            check("hold_pc",     pc,                   exp_pc);
            check("hold_pc4",    pc_plus4,             exp_pc + 32'd4);
            imem_ack   = 1'($urandom);   // must be ignored outside FETCH
            imem_rdata = $urandom;
            retire     = (i == delay);
            jmp        = (i == delay) ? j : 1'($urandom);
            branch     = (i == delay) ? b : 1'($urandom);
            zero       = (i == delay) ? z : 1'($urandom);
            tick();
        end
        exp_pc   = model_next(exp_pc, cur_word, j, b, z);
        imem_ack = 1'b0;
        retire   = 1'b0;
        jmp      = 1'b0;
        branch   = 1'b0;
        zero     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        retire = 1'b0; branch = 1'b0; zero = 1'b0; jmp = 1'b0;
        exp_pc = RST_PC; cur_word = 32'd0; n_fetched = 0; n_wait = 0;

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_pc",    pc,                   RST_PC);
        check("rst_op",    {26'd0, op},          32'd0);
        rst_n = 1'b1;
        #1;
        check("boot_req", {31'd0, imem_req}, 32'd0);
        tick();

        // Zero-wait lw at reset PC
        check("first_addr", imem_addr, 32'h0000_0040);
        do_fetch(32'h8C01_0004, 0);
        check("lw_op", {26'd0, op}, 32'h23);
        do_hold(0, 1'b0, 1'b0, 1'b0);

        // Three wait states, then a jump to 0x100
        do_fetch(32'h0800_0040, 3);
        do_hold(1, 1'b1, 1'b0, 1'b0);
        check("jump_0x100", imem_addr, 32'h0000_0100);

        // Taken beq, imm = -2
        do_fetch(32'h1022_FFFE, 0);
        do_hold(0, 1'b0, 1'b1, 1'b1);
        check("beq_taken", imem_addr, 32'h0000_00FC);

        // Back to 0x100, not-taken beq
        do_fetch(32'h0800_0040, 1);
        do_hold(0, 1'b1, 1'b0, 1'b0);
        do_fetch(32'h1022_FFFE, 0);
        do_hold(2, 1'b0, 1'b1, 1'b0);
        check("beq_not_taken", imem_addr, 32'h0000_0104);

        // Wrap: jump to 0, branch back to 0xFFFF_FFFC, fall through to 0
        do_fetch(32'h0800_0000, 0);
        do_hold(0, 1'b1, 1'b0, 1'b0);
        do_fetch(32'h1022_FFFE, 0);
        do_hold(0, 1'b0, 1'b1, 1'b1);
        check("branch_wrap", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0000, 0);
        check("pc4_wrap", pc_plus4, 32'h0000_0000);
        do_hold(0, 1'b0, 1'b0, 1'b0);
        check("seq_wrap", imem_addr, 32'h0000_0000);

        // Reach 0x1000_0000, then jump with branch also asserted
        do_fetch(32'h0BFF_FFFF, 0);
        do_hold(0, 1'b1, 1'b0, 1'b0);
        do_fetch(32'h0000_0000, 0);
        do_hold(0, 1'b0, 1'b0, 1'b0);
        check("at_region1", imem_addr, 32'h1000_0000);
        do_fetch(32'h0810_0010, 0);
        do_hold(0, 1'b1, 1'b1, 1'b1);
        check("jmp_priority", imem_addr, 32'h1040_0040);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            w = $urandom;
            do_fetch(w, int'($urandom_range(0, 3)));
            do_hold(int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom));
        end

        // Async reset in FETCH while ack is high
        check("pre_reset_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_req",   {31'd0, imem_req},    32'd0);
        check("arst_pc",    pc,                   RST_PC);
        check("arst_instr", instr,                32'd0);
        tick();
        check("arst_not_latched", instr, 32'd0);
        check("arst_hold_valid",  {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b0;
        exp_pc = RST_PC; n_fetched = 0; n_wait = 0;
        rst_n = 1'b1;
        #1;
        check("reboot_req", {31'd0, imem_req}, 32'd0);
        tick();
        do_fetch(32'h8C01_0004, 2);
        do_hold(0, 1'b0, 1'b0, 1'b0);
        check("after_reset_seq", imem_addr, 32'h0000_0044);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
